// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory itself.
//   - arb_state_e      : arbiter FSM encoding
//   - MMIO_BASE_DEFAULT: first address of the LED/digital-tube MMIO window
//   - MMIO_*_ADDR      : MMIO register addresses decoded by the data memory
//   - is_mmio()        : address-window decode helper
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] MMIO_LED_ADDR     = 32'h4000_000C;
    localparam logic [31:0] MMIO_TUBE_ADDR    = 32'h4000_0010;

    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter for the data-memory arbiter.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clr         : synchronous clear (wins over inc)
//   inc         : increment, saturating at all-ones
//   cnt         : current count
//   at_limit    : cnt == LIMIT
module dmem_arbiter_starve_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory (and its MMIO
// window) between the CPU MEM stage and a DMA/loader requester. The CPU has
// fixed priority; a starvation counter forces a one-cycle CPU stall so a
// pending DMA request is served within STARVE_LIMIT+1 cycles.
// Ports:
//   clk, reset                          : clock, asynchronous active-low reset
//   cpu_memread/memwrite/is_lb/addr/wdata: MEM-stage access from EX/MEM
//   cpu_rdata                           : load data (memory read data, unmuxed)
//   cpu_stall                           : one-cycle pipeline freeze in FORCE
//   dma_req/we/addr/wdata               : DMA request, held until dma_gnt
//   dma_gnt, dma_err                    : accept / refuse (MMIO) this cycle
//   dma_rdata, dma_rvalid               : registered read return, latency 1
//   mem_*                               : data-memory port
//
// state | meaning
// IDLE  | no DMA request blocked; DMA granted at once if CPU is not accessing
// WAIT  | DMA request blocked by CPU; cnt counts blocked cycles
// FORCE | CPU stalled for one cycle, DMA owns the memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          STARVE_LIMIT = 8,
    parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
    parameter int          CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic        cpu_is_lb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_is_lb,
    input  logic [31:0] mem_rdata
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic             cpu_access;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             at_limit;
    logic [CNT_W-1:0] cnt;

    assign cpu_access = cpu_memread | cpu_memwrite;

    dmem_arbiter_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall is a pure decode of the registered state: no input-to-stall path.
    assign cpu_stall = (state == FORCE);

    always_comb begin
        state_next = state;
        dma_gnt    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                // cnt is always zero here, so one increment loads 1.
                if (dma_req) begin
                    if (!cpu_access) begin
                        dma_gnt = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_inc    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!dma_req) begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end else if (!cpu_access) begin
                    dma_gnt    = 1'b1;
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end else if (at_limit) begin
                    state_next = FORCE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FORCE: begin
                dma_gnt    = dma_req;
                state_next = IDLE;
                cnt_clr    = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    assign dma_err = dma_gnt & is_mmio(dma_addr, MMIO_BASE);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = cpu_memread;
        mem_write = cpu_memwrite;
        mem_is_lb = cpu_is_lb;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = ~dma_we;
            mem_write = dma_we & ~dma_err;
            mem_is_lb = 1'b0;
        end else if (cpu_stall) begin
            // The stalled instruction replays next cycle; keep it off the bus
            // now so a store is not performed twice.
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_is_lb = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= dma_err ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic        cpu_is_lb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_err;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_is_lb;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [256];
    logic [31:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(
        .STARVE_LIMIT (8),
        .MMIO_BASE    (32'h4000_0000),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_is_lb    (cpu_is_lb),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_gnt      (dma_gnt),
        .dma_err      (dma_err),
        .dma_rdata    (dma_rdata),
        .dma_rvalid   (dma_rvalid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_is_lb    (mem_is_lb),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, write on rising edge, LED register in MMIO.
    assign mem_rdata = tb_mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write) begin
            if (mem_addr == MMIO_LED_ADDR) led <= mem_wdata;
            else if (mem_addr < 32'h4000_0000) tb_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // n cycles in which the DMA request must stay blocked with no stall.
    task automatic blocked_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_nognt"}, {31'b0, dma_gnt}, 32'd0);
            check({tag, "_nostall"}, {31'b0, cpu_stall}, 32'd0);
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h1000_0000 + i;
        tb_mem[8'h10] = 32'hCAFE_F00D;
        tb_mem[8'h30] = 32'hA5A5_A5A5;
        led          = 32'h0000_0005;
        reset        = 1'b0;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_is_lb    = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        dma_req      = 1'b0;
        dma_we       = 1'b0;
        dma_addr     = 32'h0;
        dma_wdata    = 32'h0;

        // Reset state
        #1;
        check("rst_stall",  {31'b0, cpu_stall},  32'd0);
        check("rst_gnt",    {31'b0, dma_gnt},    32'd0);
        check("rst_err",    {31'b0, dma_err},    32'd0);
        check("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
        check("rst_rdata",  dma_rdata,           32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Idle CPU: zero-latency read grant, data one cycle later
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        @(negedge clk);
        check("idle_gnt",     {31'b0, dma_gnt},   32'd1);
        check("idle_err",     {31'b0, dma_err},   32'd0);
        check("idle_stall",   {31'b0, cpu_stall}, 32'd0);
        check("idle_memread", {31'b0, mem_read},  32'd1);
        check("idle_memaddr", mem_addr,           32'h10);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check("idle_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("idle_rdata",  dma_rdata,           32'hCAFE_F00D);
        check("idle_stall2", {31'b0, cpu_stall},  32'd0);
        next_cycle();
        @(negedge clk);
        check("idle_rvalid_drop", {31'b0, dma_rvalid}, 32'd0);
        next_cycle();

        // Starvation: CPU loads every cycle, DMA write forced in after 9 blocked cycles
        cpu_memread = 1'b1; cpu_addr = 32'h30;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
        blocked_cycles(9, "starve");
        @(negedge clk);
        check("starve_stall",    {31'b0, cpu_stall}, 32'd1);
        check("starve_gnt",      {31'b0, dma_gnt},   32'd1);
        check("starve_memwrite", {31'b0, mem_write}, 32'd1);
        check("starve_memaddr",  mem_addr,           32'h20);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check("starve_memdata", tb_mem[8'h20],      32'h1234_5678);
        check("starve_unstall", {31'b0, cpu_stall}, 32'd0);
        check("starve_cpuread", {31'b0, mem_read},  32'd1);
        check("starve_cpudata", cpu_rdata,          32'hA5A5_A5A5);
        next_cycle();

        // CPU gap: blocked 3 cycles, granted in first idle cycle
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h24; dma_wdata = 32'hDEAD_BEEF;
        blocked_cycles(3, "gap");
        cpu_memread = 1'b0;
        @(negedge clk);
        check("gap_gnt",      {31'b0, dma_gnt},   32'd1);
        check("gap_stall",    {31'b0, cpu_stall}, 32'd0);
        check("gap_memwrite", {31'b0, mem_write}, 32'd1);
        next_cycle();
        dma_req = 1'b0; cpu_memread = 1'b1;
        @(negedge clk);
        check("gap_memdata", tb_mem[8'h24], 32'hDEAD_BEEF);
        next_cycle();
        // Counter must have restarted: a full 9 blocked cycles again
        dma_req = 1'b1; dma_addr = 32'h28; dma_wdata = 32'h0000_0001;
        blocked_cycles(9, "gap_recount");
        @(negedge clk);
        check("gap_recount_stall", {31'b0, cpu_stall}, 32'd1);
        check("gap_recount_gnt",   {31'b0, dma_gnt},   32'd1);
        next_cycle();
        dma_req = 1'b0;
        next_cycle();

        // Withdrawal in WAIT with cnt=5, then a fresh request counts from 1
        dma_req = 1'b1; dma_addr = 32'h2C; dma_wdata = 32'h0000_0002;
        blocked_cycles(5, "wd");
        dma_req = 1'b0;
        @(negedge clk);
        check("wd_gnt",   {31'b0, dma_gnt},   32'd0);
        check("wd_stall", {31'b0, cpu_stall}, 32'd0);
        next_cycle();
        dma_req = 1'b1;
        blocked_cycles(9, "wd_recount");
        @(negedge clk);
        check("wd_recount_stall", {31'b0, cpu_stall}, 32'd1);
        check("wd_recount_gnt",   {31'b0, dma_gnt},   32'd1);
        next_cycle();
        dma_req = 1'b0; cpu_memread = 1'b0;
        next_cycle();

        // MMIO guard
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h4000_000C; dma_wdata = 32'h0000_00FF;
        @(negedge clk);
        check("mmio_w_gnt",      {31'b0, dma_gnt},   32'd1);
        check("mmio_w_err",      {31'b0, dma_err},   32'd1);
        check("mmio_w_memwrite", {31'b0, mem_write}, 32'd0);
        next_cycle();
        check("mmio_w_led", led, 32'h0000_0005);
        dma_we = 1'b0; dma_addr = 32'h4000_0010;
        @(negedge clk);
        check("mmio_r_gnt", {31'b0, dma_gnt}, 32'd1);
        check("mmio_r_err", {31'b0, dma_err}, 32'd1);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check("mmio_r_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("mmio_r_rdata",  dma_rdata,           32'd0);
        check("mmio_r_noerr",  {31'b0, dma_err},    32'd0);
        next_cycle();

        // Reset mid-FORCE: load rdata with nonzero first
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check("pre_rst_rdata", dma_rdata, 32'hCAFE_F00D);
        next_cycle();
        cpu_memread = 1'b1; cpu_addr = 32'h30;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h34; dma_wdata = 32'h7777_7777;
        blocked_cycles(9, "rstf");
        @(negedge clk);
        check("rstf_stall_on", {31'b0, cpu_stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstf_stall_off", {31'b0, cpu_stall},  32'd0);
        check("rstf_gnt",       {31'b0, dma_gnt},    32'd0);
        check("rstf_rvalid",    {31'b0, dma_rvalid}, 32'd0);
        check("rstf_rdata",     dma_rdata,           32'd0);
        dma_req = 1'b0; cpu_memread = 1'b0;
        next_cycle();
        check("rstf_nowrite", tb_mem[8'h34], 32'h1000_0034);
        reset = 1'b1;
        next_cycle();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        @(negedge clk);
        check("rstf_idle_gnt",   {31'b0, dma_gnt},   32'd1);
        check("rstf_idle_stall", {31'b0, cpu_stall}, 32'd0);
        next_cycle();
        dma_req = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
